// File: rtl/apb_reg_completer.sv
// APB completer with a bank of NUM_REGS read/write registers.
// Each transfer takes WAIT_STATES wait cycles. Writes honour the byte strobes.
// A misaligned or out-of-range address gets an error response.

package apb_pkg;
   parameter int ADDR_WIDTH = 32;
   parameter int DATA_WIDTH = 32;
   parameter int STRB_WIDTH = DATA_WIDTH / 8;
   parameter int ALIGNBITS  = $clog2(STRB_WIDTH);
endpackage

module apb_reg_completer
   import apb_pkg::*;
#(
   parameter int                    NUM_REGS    = 8,
   parameter logic [ADDR_WIDTH-1:0] BASE_ADDR   = '0,
   parameter int                    WAIT_STATES = 1
) (
   input  logic                  PCLK,
   input  logic                  PRESET,
   input  logic                  PSEL,
   input  logic                  PENABLE,
   input  logic                  PWRITE,
   input  logic [ADDR_WIDTH-1:0] PADDR,
   input  logic [DATA_WIDTH-1:0] PWDATA,
   input  logic [STRB_WIDTH-1:0] PSTRB,
   output logic [DATA_WIDTH-1:0] PRDATA,
   output logic                  PREADY,
   output logic                  PSLVERR
);

   // A width of at least one bit keeps a single-register bank legal.
   localparam int IDX_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_WAIT = 2'd1,
      S_RESP = 2'd2
   } state_t;

   // ---------------------------------------------------------------
   // State and registers
   // ---------------------------------------------------------------
   state_t                  r_state;
   state_t                  w_state_next;
   logic [3:0]              r_cnt;
   logic [3:0]              w_cnt_next;

   // Transfer attributes captured in the setup cycle.
   logic                    r_write;
   logic                    r_err;
   logic [IDX_W-1:0]        r_idx;
   logic [DATA_WIDTH-1:0]   r_wdata;
   logic [STRB_WIDTH-1:0]   r_strb;

   logic [DATA_WIDTH-1:0]   r_regs [NUM_REGS];
   logic [DATA_WIDTH-1:0]   w_reg_next [NUM_REGS];
   logic [NUM_REGS-1:0]     w_reg_hit;

   logic [DATA_WIDTH-1:0]   r_prdata;
   logic                    r_pready;
   logic                    r_pslverr;

   // ---------------------------------------------------------------
   // Address decode in the setup cycle
   // ---------------------------------------------------------------
   logic                    w_setup;
   logic [ADDR_WIDTH-1:0]   w_off;
   logic [ADDR_WIDTH-1:0]   w_word;
   logic                    w_err;
   logic [IDX_W-1:0]        w_idx;
   logic                    w_latch;

   assign w_setup = PSEL & ~PENABLE;
   assign w_off   = PADDR - BASE_ADDR;
   assign w_word  = w_off >> ALIGNBITS;
   assign w_err   = (PADDR < BASE_ADDR)
                  | (w_off[ALIGNBITS-1:0] != '0)
                  | (w_word >= ADDR_WIDTH'(NUM_REGS));
   // Truncation is safe: any index that does not fit also sets w_err.
   assign w_idx   = w_word[IDX_W-1:0];

   // Setups are only accepted from IDLE.
   assign w_latch = (r_state == S_IDLE) & w_setup;

   // With zero wait states, RESP is entered straight from the setup cycle.
   // The response must then use the live decode, not the captured copy.
   logic                    w_cur_write;
   logic                    w_cur_err;
   logic [IDX_W-1:0]        w_cur_idx;

   assign w_cur_write = w_latch ? PWRITE : r_write;
   assign w_cur_err   = w_latch ? w_err  : r_err;
   assign w_cur_idx   = w_latch ? w_idx  : r_idx;

   // ---------------------------------------------------------------
   // FSM
   // ---------------------------------------------------------------
   // State register and wait counter.
   always_ff @(posedge PCLK) begin
      if (PRESET) begin
         r_state <= S_IDLE;
         r_cnt   <= '0;
      end else begin
         r_state <= w_state_next;
         r_cnt   <= w_cnt_next;
      end
   end

   // Next-state logic: IDLE -> (WAIT) -> RESP -> IDLE.
   // Dropping PSEL during WAIT aborts the transfer.
   always_comb begin
      w_state_next = r_state;
      w_cnt_next   = r_cnt;
      case (r_state)
         S_IDLE: begin
            if (w_setup) begin
               if (WAIT_STATES == 0) begin
                  w_state_next = S_RESP;
               end else begin
                  w_cnt_next   = 4'(WAIT_STATES);
                  w_state_next = S_WAIT;
               end
            end
         end
         S_WAIT: begin
            if (!PSEL) begin
               w_state_next = S_IDLE;
               w_cnt_next   = '0;
            end else if (r_cnt == 4'd1) begin
               w_state_next = S_RESP;
               w_cnt_next   = '0;
            end else begin
               w_cnt_next   = r_cnt - 4'd1;
            end
         end
         S_RESP: begin
            w_state_next = S_IDLE;
         end
         default: begin
            w_state_next = S_IDLE;
            w_cnt_next   = '0;
         end
      endcase
   end

   // Capture the transfer attributes in the setup cycle. Later bus changes are ignored.
   always_ff @(posedge PCLK) begin
      if (PRESET) begin
         r_write <= 1'b0;
         r_err   <= 1'b0;
         r_idx   <= '0;
         r_wdata <= '0;
         r_strb  <= '0;
      end else if (w_latch) begin
         r_write <= PWRITE;
         r_err   <= w_err;
         r_idx   <= w_idx;
         r_wdata <= PWDATA;
         r_strb  <= PSTRB;
      end
   end

   // ---------------------------------------------------------------
   // Register bank
   // ---------------------------------------------------------------
   // A write commits on the edge that ends the RESP cycle. This happens only
   // for a valid address, and reset overrides it.
   logic                    w_we;
   logic [DATA_WIDTH-1:0]   w_bmask;

   assign w_we = (r_state == S_RESP) & r_write & ~r_err;

   // Expand each strobe bit into a full byte-lane mask.
   generate
      for (genvar gi = 0; gi < STRB_WIDTH; gi++) begin : g_bmask
         assign w_bmask[8*gi +: 8] = {8{r_strb[gi]}};
      end
   endgenerate

   // Compute the next value of each register. Bytes with a zero strobe keep their old value.
   generate
      for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_reg
         assign w_reg_hit[gi]  = w_we & (r_idx == IDX_W'(gi));
         assign w_reg_next[gi] = w_reg_hit[gi]
                               ? ((r_regs[gi] & ~w_bmask) | (r_wdata & w_bmask))
                               : r_regs[gi];
      end
   endgenerate

   // Register bank storage, cleared by reset.
   always_ff @(posedge PCLK) begin
      if (PRESET) begin
         for (int i = 0; i < NUM_REGS; i++) begin
            r_regs[i] <= '0;
         end
      end else begin
         for (int i = 0; i < NUM_REGS; i++) begin
            r_regs[i] <= w_reg_next[i];
         end
      end
   end

   // ---------------------------------------------------------------
   // Registered response
   // ---------------------------------------------------------------
   logic                    w_enter_resp;
   logic [DATA_WIDTH-1:0]   w_rd_word;

   assign w_enter_resp = (w_state_next == S_RESP);
   // A register write can only complete at the end of a RESP cycle. No read
   // enters RESP on that same edge, so this sample is always the pre-write value.
   assign w_rd_word    = w_cur_err ? '0 : r_regs[w_cur_idx];

   // Load the response outputs on the edge that enters RESP. They are zero in every other cycle.
   always_ff @(posedge PCLK) begin
      if (PRESET) begin
         r_pready  <= 1'b0;
         r_pslverr <= 1'b0;
         r_prdata  <= '0;
      end else begin
         r_pready  <= w_enter_resp;
         r_pslverr <= w_enter_resp & w_cur_err;
         r_prdata  <= (w_enter_resp & ~w_cur_write & ~w_cur_err) ? w_rd_word : '0;
      end
   end

   assign PREADY  = r_pready;
   assign PSLVERR = r_pslverr;
   assign PRDATA  = r_prdata;

endmodule

// File: tb/tb_apb_reg_completer.sv
// Directed bench for apb_reg_completer.
// dut1 uses WAIT_STATES=1 and dut3 uses WAIT_STATES=3. Both share the requester signals.

module tb_apb_reg_completer;

   logic        PCLK = 1'b0;
   logic        PRESET;
   logic        PSEL;
   logic        PENABLE;
   logic        PWRITE;
   logic [31:0] PADDR;
   logic [31:0] PWDATA;
   logic [3:0]  PSTRB;
   logic [31:0] rd1, rd3;
   logic        rdy1, rdy3, err1, err3;

   int n_cmp  = 0;
   int n_fail = 0;

   always #5 PCLK = ~PCLK;

   apb_reg_completer #(.NUM_REGS(8), .BASE_ADDR(32'h0), .WAIT_STATES(1)) dut1 (
      .PCLK(PCLK), .PRESET(PRESET), .PSEL(PSEL), .PENABLE(PENABLE),
      .PWRITE(PWRITE), .PADDR(PADDR), .PWDATA(PWDATA), .PSTRB(PSTRB),
      .PRDATA(rd1), .PREADY(rdy1), .PSLVERR(err1)
   );

   apb_reg_completer #(.NUM_REGS(8), .BASE_ADDR(32'h0), .WAIT_STATES(3)) dut3 (
      .PCLK(PCLK), .PRESET(PRESET), .PSEL(PSEL), .PENABLE(PENABLE),
      .PWRITE(PWRITE), .PADDR(PADDR), .PWDATA(PWDATA), .PSTRB(PSTRB),
      .PRDATA(rd3), .PREADY(rdy3), .PSLVERR(err3)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      $display("check %-18s observed=0x%08h expected=0x%08h", tag, obs, exp);
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
      end
   endtask

   // Run one transfer. Call it #1 after a rising edge and it drives setup at once.
   // It returns #1 after the edge that ends the PREADY cycle, with the bus idle.
   task automatic xfer(input bit use3, input bit wr, input logic [31:0] addr,
                       input logic [31:0] data, input logic [3:0] strb,
                       output logic [31:0] rdata, output logic serr, output int lat);
      bit done;
      done  = 1'b0;
      lat   = 0;
      rdata = '0;
      serr  = 1'b0;
      PSEL = 1'b1; PENABLE = 1'b0; PWRITE = wr;
      PADDR = addr; PWDATA = data; PSTRB = strb;
      for (int k = 1; k <= 40 && !done; k++) begin
         @(posedge PCLK); #1;
         PENABLE = 1'b1;
         @(negedge PCLK);
         if ((use3 ? rdy3 : rdy1) === 1'b1) begin
            done  = 1'b1;
            lat   = k;
            rdata = use3 ? rd3 : rd1;
            serr  = use3 ? err3 : err1;
         end
      end
      chk("xfer_completed", {31'b0, done}, 32'd1);
      @(posedge PCLK); #1;
      PSEL = 1'b0; PENABLE = 1'b0;
      $display("xfer dut%0d %s addr=0x%08h wdata=0x%08h strb=%b -> rdata=0x%08h slverr=%0b lat=%0d",
               use3 ? 3 : 1, wr ? "WR" : "RD", addr, data, strb, rdata, serr, lat);
   endtask

   logic [31:0] rdata;
   logic        serr;
   int          lat;
   logic        seen;

   initial begin
      PRESET = 1'b1; PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
      PADDR = '0; PWDATA = '0; PSTRB = '0;

      // 1. Hold reset for two cycles, then check the outputs and every register.
      repeat (2) @(posedge PCLK);
      @(negedge PCLK);
      chk("rst_pready1", {31'b0, rdy1}, 32'd0);
      chk("rst_pslverr1", {31'b0, err1}, 32'd0);
      chk("rst_prdata1", rd1, 32'h0);
      chk("rst_pready3", {31'b0, rdy3}, 32'd0);
      @(posedge PCLK); #1;
      PRESET = 1'b0;
      for (int r = 0; r < 8; r++) begin
         xfer(1'b0, 1'b0, 32'(r * 4), 32'h0, 4'h0, rdata, serr, lat);
         chk($sformatf("rst_reg%0d", r), rdata, 32'h0);
      end

      // 2. With WAIT_STATES=1, PREADY rises two cycles after setup and lasts one cycle.
      xfer(1'b0, 1'b1, 32'h4, 32'hDEADBEEF, 4'hF, rdata, serr, lat);
      chk("wr4_latency", 32'(lat), 32'd2);
      chk("wr4_pslverr", {31'b0, serr}, 32'd0);
      @(negedge PCLK);
      chk("pready_one_cycle", {31'b0, rdy1}, 32'd0);
      @(posedge PCLK); #1;
      xfer(1'b0, 1'b0, 32'h4, 32'h0, 4'h0, rdata, serr, lat);
      chk("rd4_data", rdata, 32'hDEADBEEF);
      chk("rd4_latency", 32'(lat), 32'd2);

      // 3. A write with PSTRB=4'b0101 updates bytes 0 and 2 only. PSTRB=0 writes nothing.
      xfer(1'b0, 1'b1, 32'h8, 32'h11223344, 4'hF, rdata, serr, lat);
      xfer(1'b0, 1'b1, 32'h8, 32'hAABBCCDD, 4'b0101, rdata, serr, lat);
      xfer(1'b0, 1'b0, 32'h8, 32'h0, 4'h0, rdata, serr, lat);
      chk("strb_0101", rdata, 32'h11BB33DD);
      xfer(1'b0, 1'b1, 32'h8, 32'hFFFFFFFF, 4'h0, rdata, serr, lat);
      xfer(1'b0, 1'b0, 32'h8, 32'h0, 4'hF, rdata, serr, lat);
      chk("strb_none", rdata, 32'h11BB33DD);

      // 4. Misaligned and out-of-range addresses report an error and write nothing.
      xfer(1'b0, 1'b1, 32'h6, 32'hFFFFFFFF, 4'hF, rdata, serr, lat);
      chk("misalign_slverr", {31'b0, serr}, 32'd1);
      xfer(1'b0, 1'b1, 32'h20, 32'hFFFFFFFF, 4'hF, rdata, serr, lat);
      chk("range_wr_slverr", {31'b0, serr}, 32'd1);
      xfer(1'b0, 1'b0, 32'h4, 32'h0, 4'h0, rdata, serr, lat);
      chk("after_err_reg4", rdata, 32'hDEADBEEF);
      xfer(1'b0, 1'b0, 32'h0, 32'h0, 4'h0, rdata, serr, lat);
      chk("after_err_reg0", rdata, 32'h0);
      xfer(1'b0, 1'b0, 32'h20, 32'h0, 4'h0, rdata, serr, lat);
      chk("range_rd_data", rdata, 32'h0);
      chk("range_rd_slverr", {31'b0, serr}, 32'd1);
      // The last valid register sits at 0x1C.
      xfer(1'b0, 1'b1, 32'h1C, 32'hCAFEF00D, 4'hF, rdata, serr, lat);
      chk("last_wr_slverr", {31'b0, serr}, 32'd0);
      xfer(1'b0, 1'b0, 32'h1C, 32'h0, 4'h0, rdata, serr, lat);
      chk("last_rd_data", rdata, 32'hCAFEF00D);

      // 5. Back-to-back transfers: the read setup follows the PREADY cycle directly.
      xfer(1'b0, 1'b1, 32'h0, 32'h1, 4'hF, rdata, serr, lat);
      xfer(1'b0, 1'b0, 32'h0, 32'h0, 4'h0, rdata, serr, lat);
      chk("b2b_rd_data", rdata, 32'h1);
      chk("b2b_rd_latency", 32'(lat), 32'd2);

      // 6. With WAIT_STATES=3, check an aborted transfer and a reset in the WAIT state.
      PRESET = 1'b1;
      @(posedge PCLK); #1;
      PRESET = 1'b0;
      xfer(1'b1, 1'b1, 32'hC, 32'h00000055, 4'hF, rdata, serr, lat);
      chk("ws3_wr_latency", 32'(lat), 32'd4);

      // The requester drops PSEL while dut3 is still in WAIT.
      PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1;
      PADDR = 32'hC; PWDATA = 32'hFFFFFFFF; PSTRB = 4'hF;
      @(posedge PCLK); #1;
      PENABLE = 1'b1;
      @(posedge PCLK); #1;
      PSEL = 1'b0; PENABLE = 1'b0;
      seen = 1'b0;
      repeat (6) begin
         @(negedge PCLK);
         seen = seen | rdy3;
         @(posedge PCLK); #1;
      end
      chk("abort_no_pready", {31'b0, seen}, 32'd0);
      xfer(1'b1, 1'b0, 32'hC, 32'h0, 4'h0, rdata, serr, lat);
      chk("abort_no_write", rdata, 32'h00000055);
      chk("abort_next_lat", 32'(lat), 32'd4);

      // A reset pulse while dut3 is in WAIT.
      PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1;
      PADDR = 32'hC; PWDATA = 32'h00000077; PSTRB = 4'hF;
      @(posedge PCLK); #1;
      PENABLE = 1'b1;
      @(posedge PCLK); #1;
      PRESET = 1'b1; PSEL = 1'b0; PENABLE = 1'b0;
      @(posedge PCLK); #1;
      PRESET = 1'b0;
      seen = 1'b0;
      repeat (5) begin
         @(negedge PCLK);
         seen = seen | rdy3;
         @(posedge PCLK); #1;
      end
      chk("rstabort_no_pready", {31'b0, seen}, 32'd0);
      xfer(1'b1, 1'b0, 32'hC, 32'h0, 4'h0, rdata, serr, lat);
      chk("rstabort_reg_clear", rdata, 32'h0);
      xfer(1'b1, 1'b1, 32'h10, 32'h00000099, 4'hF, rdata, serr, lat);
      chk("rstabort_next_lat", 32'(lat), 32'd4);
      xfer(1'b1, 1'b0, 32'h10, 32'h0, 4'h0, rdata, serr, lat);
      chk("rstabort_next_rd", rdata, 32'h00000099);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
